// File: rtl/alu_ctrl_decode_stage_if.sv
// ALU control decode stage bundle.
// Decode inputs from IF/ID and registered ID/EX control outputs.
interface alu_ctrl_decode_stage_if #(
  parameter int INSTR_WIDTH       = 32,
  parameter int ILLEGAL_CNT_WIDTH = 8
);
  logic [INSTR_WIDTH-1:0]       Instr;
  logic                         InValid;
  logic                         Stall;
  logic                         Flush;
  logic [3:0]                   ALUControl;
  logic                         ALUSrcB;
  logic [4:0]                   Rd;
  logic                         RegWrite;
  logic                         Illegal;
  logic                         OutValid;
  logic [ILLEGAL_CNT_WIDTH-1:0] IllegalCount;

  modport master (
    output Instr, InValid, Stall, Flush,
    input  ALUControl, ALUSrcB, Rd, RegWrite,
    input  Illegal, OutValid, IllegalCount
  );

  modport slave (
    input  Instr, InValid, Stall, Flush,
    output ALUControl, ALUSrcB, Rd, RegWrite,
    output Illegal, OutValid, IllegalCount
  );
endinterface

// File: rtl/alu_ctrl_decode_stage.sv
// RV32I ALU control decode stage.
// Registered ID/EX control slice with illegal-instruction counter.
module alu_ctrl_decode_stage #(
  parameter int INSTR_WIDTH       = 32,
  parameter int ILLEGAL_CNT_WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  alu_ctrl_decode_stage_if.slave bus
);
  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SRL  = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SLTU = 4'b1001;

  localparam logic [6:0] F7_Z = 7'b0000000;
  localparam logic [6:0] F7_A = 7'b0100000;

  localparam logic [ILLEGAL_CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rd;

  assign opcode = bus.Instr[6:0];
  assign funct3 = bus.Instr[14:12];
  assign funct7 = bus.Instr[31:25];
  assign rd     = bus.Instr[11:7];

  // rs1/rs2 fields are consumed by the register file, not here
  logic unused_rs;
  assign unused_rs = ^bus.Instr[24:15];

  logic [3:0] d_alu;
  logic       d_srcb;
  logic       d_wr;
  logic       d_ill;
  logic [3:0] f3_op;

  // Shared funct3 -> ALU op mapping for R-type and I-type ALU
  always_comb begin
    f3_op = OP_ADD;
    unique case (funct3)
      3'b000: f3_op = OP_ADD;
      3'b001: f3_op = OP_SLL;
      3'b010: f3_op = OP_SLT;
      3'b011: f3_op = OP_SLTU;
      3'b100: f3_op = OP_XOR;
      3'b101: f3_op = OP_SRL;
      3'b110: f3_op = OP_OR;
      3'b111: f3_op = OP_AND;
      default: f3_op = OP_ADD;
    endcase
  end

  // Opcode decode into raw control, then legality/rd/valid masking
  always_comb begin
    d_alu  = OP_ADD;
    d_srcb = 1'b0;
    d_wr   = 1'b0;
    d_ill  = 1'b0;
    unique case (opcode)
      7'b0110011: begin
        d_wr  = 1'b1;
        d_alu = f3_op;
        if (funct3 == 3'b000 || funct3 == 3'b101) begin
          if (funct7 == F7_A)
            d_alu = (funct3 == 3'b000) ? OP_SUB : OP_SRA;
          else if (funct7 != F7_Z)
            d_ill = 1'b1;
        end else if (funct7 != F7_Z) begin
          d_ill = 1'b1;
        end
      end
      7'b0010011: begin
        d_wr   = 1'b1;
        d_srcb = 1'b1;
        d_alu  = f3_op;
        if (funct3 == 3'b101) begin
          if (funct7 == F7_A)
            d_alu = OP_SRA;
          else if (funct7 != F7_Z)
            d_ill = 1'b1;
        end else if (funct3 == 3'b001) begin
          d_ill = (funct7 != F7_Z);
        end
      end
      7'b0000011, 7'b0110111: begin
        d_wr   = 1'b1;
        d_srcb = 1'b1;
      end
      7'b0100011: begin
        d_srcb = 1'b1;
      end
      7'b1100011: begin
        unique case (funct3[2:1])
          2'b00: d_alu = OP_SUB;
          2'b10: d_alu = OP_SLT;
          2'b11: d_alu = OP_SLTU;
          default: d_ill = 1'b1;
        endcase
      end
      default: d_ill = 1'b1;
    endcase
    if (d_ill) begin
      d_alu  = OP_ADD;
      d_srcb = 1'b0;
      d_wr   = 1'b0;
    end
    if (rd == 5'd0 || !bus.InValid)
      d_wr = 1'b0;
    if (!bus.InValid)
      d_ill = 1'b0;
  end

  // ID/EX register: reset > flush > stall > capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.ALUControl   <= OP_ADD;
      bus.ALUSrcB      <= 1'b0;
      bus.Rd           <= 5'd0;
      bus.RegWrite     <= 1'b0;
      bus.Illegal      <= 1'b0;
      bus.OutValid     <= 1'b0;
      bus.IllegalCount <= '0;
    end else if (bus.Flush) begin
      bus.ALUControl <= OP_ADD;
      bus.ALUSrcB    <= 1'b0;
      bus.Rd         <= 5'd0;
      bus.RegWrite   <= 1'b0;
      bus.Illegal    <= 1'b0;
      bus.OutValid   <= 1'b0;
    end else if (!bus.Stall) begin
      bus.ALUControl <= d_alu;
      bus.ALUSrcB    <= d_srcb;
      bus.Rd         <= rd;
      bus.RegWrite   <= d_wr;
      bus.Illegal    <= d_ill;
      bus.OutValid   <= bus.InValid;
      if (d_ill && bus.IllegalCount != CNT_MAX)
        bus.IllegalCount <= bus.IllegalCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Testbench for alu_ctrl_decode_stage.
// Directed table, corner sequences, randomized model check.
module tb_alu_ctrl_decode_stage;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  alu_ctrl_decode_stage_if #(.INSTR_WIDTH(32), .ILLEGAL_CNT_WIDTH(8)) bus ();

  alu_ctrl_decode_stage #(.INSTR_WIDTH(32), .ILLEGAL_CNT_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0] alu;
    logic       srcb;
    logic [4:0] rd;
    logic       wr;
    logic       ill;
    logic       ov;
    logic [7:0] cnt;
  } obs_t;

  typedef struct {
    logic [31:0] ins;
    logic        v;
    obs_t        e;
  } vec_t;

  int   vectors = 0;
  int   miscompares = 0;
  obs_t m;

  function automatic obs_t act();
    obs_t o;
    o.alu  = bus.ALUControl;
    o.srcb = bus.ALUSrcB;
    o.rd   = bus.Rd;
    o.wr   = bus.RegWrite;
    o.ill  = bus.Illegal;
    o.ov   = bus.OutValid;
    o.cnt  = bus.IllegalCount;
    return o;
  endfunction

  // Reference decode from the ISA rules; cnt left zero for caller
  function automatic obs_t ref_dec(logic [31:0] i, logic v);
    obs_t o;
    int   map [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    int   f3 = int'(i[14:12]);
    int   f7 = int'(i[31:25]);
    int   alu = 0;
    bit   legal = 1;
    bit   imm = 0;
    bit   wb = 0;
    case (i[6:0])
      7'h33: begin
        wb = 1;
        legal = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
        alu = map[f3] + ((f7 == 32) ? 1 : 0);
      end
      7'h13: begin
        wb = 1;
        imm = 1;
        alu = map[f3];
        if (f3 == 5) begin
          legal = (f7 == 0 || f7 == 32);
          alu = 6 + ((f7 == 32) ? 1 : 0);
        end else if (f3 == 1) begin
          legal = (f7 == 0);
        end
      end
      7'h03, 7'h37: begin wb = 1; imm = 1; end
      7'h23: imm = 1;
      7'h63: begin
        legal = (f3 / 2 != 1);
        alu = (f3 < 4) ? 1 : ((f3 < 6) ? 8 : 9);
      end
      default: legal = 0;
    endcase
    if (!legal) begin alu = 0; imm = 0; wb = 0; end
    o.alu  = alu[3:0];
    o.srcb = imm;
    o.rd   = i[11:7];
    o.wr   = wb && legal && v && (i[11:7] != 0);
    o.ill  = !legal && v;
    o.ov   = v;
    o.cnt  = 8'd0;
    return o;
  endfunction

  task automatic chk(input string name, input obs_t e);
    obs_t a = act();
    vectors++;
    if (a !== e) begin
      miscompares++;
      $display("FAIL %s: got alu=%h srcb=%b rd=%0d wr=%b ill=%b ov=%b cnt=%0d expected alu=%h srcb=%b rd=%0d wr=%b ill=%b ov=%b cnt=%0d",
               name, a.alu, a.srcb, a.rd, a.wr, a.ill, a.ov, a.cnt,
               e.alu, e.srcb, e.rd, e.wr, e.ill, e.ov, e.cnt);
    end
  endtask

  // One clock: drive, update model after the edge, compare
  task automatic cyc(input string name, input logic [31:0] ins,
                     input logic v, input logic st,
                     input logic fl, input logic rn);
    obs_t d;
    logic [7:0] c;
    bus.Instr = ins;
    bus.InValid = v;
    bus.Stall = st;
    bus.Flush = fl;
    rst_n = rn;
    @(posedge clk);
    if (!rn) begin
      m = '0;
    end else if (fl) begin
      c = m.cnt;
      m = '0;
      m.cnt = c;
    end else if (!st) begin
      d = ref_dec(ins, v);
      d.cnt = (d.ill && m.cnt != 8'd255) ? m.cnt + 8'd1 : m.cnt;
      m = d;
    end
    #1;
    chk(name, m);
  endtask

  function automatic vec_t mk(logic [31:0] ins, logic v, logic [3:0] alu,
                              logic srcb, logic [4:0] rd, logic wr,
                              logic ill, logic ov, logic [7:0] cnt);
    vec_t r;
    r.ins = ins;
    r.v = v;
    r.e = {alu, srcb, rd, wr, ill, ov, cnt};
    return r;
  endfunction

  function automatic logic [31:0] rnd_instr();
    logic [6:0] ops [7] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h37, 7'h63, 7'h00};
    logic [31:0] r = $urandom;
    int k = $urandom_range(0, 6);
    r[6:0] = (k == 6) ? 7'($urandom) : ops[k];
    case ($urandom_range(0, 3))
      0: r[31:25] = 7'h00;
      1: r[31:25] = 7'h20;
      default: ;
    endcase
    return r;
  endfunction

  vec_t tbl [17];

  initial begin
    tbl[0]  = mk(32'h002081B3, 1, 4'h0, 0, 3, 1, 0, 1, 0);
    tbl[1]  = mk(32'h402081B3, 1, 4'h1, 0, 3, 1, 0, 1, 0);
    tbl[2]  = mk(32'h40335293, 1, 4'h7, 1, 5, 1, 0, 1, 0);
    tbl[3]  = mk(32'h0020C063, 1, 4'h8, 0, 0, 0, 0, 1, 0);
    tbl[4]  = mk(32'h00000033, 1, 4'h0, 0, 0, 0, 0, 1, 0);
    tbl[5]  = mk(32'hFFFFFFFF, 1, 4'h0, 0, 31, 0, 1, 1, 1);
    tbl[6]  = mk(32'h00A12083, 1, 4'h0, 1, 1, 1, 0, 1, 1);
    tbl[7]  = mk(32'h00112223, 1, 4'h0, 1, 4, 0, 0, 1, 1);
    tbl[8]  = mk(32'h123452B7, 1, 4'h0, 1, 5, 1, 0, 1, 1);
    tbl[9]  = mk(32'h0020A063, 1, 4'h0, 0, 0, 0, 1, 1, 2);
    tbl[10] = mk(32'h022081B3, 1, 4'h0, 0, 3, 0, 1, 1, 3);
    tbl[11] = mk(32'hFFF0F093, 1, 4'h2, 1, 1, 1, 0, 1, 3);
    tbl[12] = mk(32'h40109093, 1, 4'h0, 0, 1, 0, 1, 1, 4);
    tbl[13] = mk(32'h0020B1B3, 1, 4'h9, 0, 3, 1, 0, 1, 4);
    tbl[14] = mk(32'h0020F063, 1, 4'h9, 0, 0, 0, 0, 1, 4);
    tbl[15] = mk(32'h002081B3, 0, 4'h0, 0, 3, 0, 0, 0, 4);
    tbl[16] = mk(32'hFFFFFFFF, 0, 4'h0, 0, 31, 0, 0, 0, 4);

    m = '0;
    bus.Instr = '0;
    bus.InValid = 1'b0;
    bus.Stall = 1'b0;
    bus.Flush = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 32'h002081B3, 1, 1, 1, 0);
    chk("reset_zero", obs_t'(0));

    for (int i = 0; i < 17; i++) begin
      cyc($sformatf("model_tbl%0d", i), tbl[i].ins, tbl[i].v, 0, 0, 1);
      chk($sformatf("tbl%0d", i), tbl[i].e);
    end

    cyc("cap_sub", 32'h402081B3, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc("stall_hold", 32'hFFFFFFFF ^ i, 1, 1, 0, 1);
    chk("stall_fixed", mk(0, 0, 4'h1, 0, 3, 1, 0, 1, 4).e);

    cyc("stall_flush", 32'hFFFFFFFF, 1, 1, 1, 1);
    chk("flush_fixed", mk(0, 0, 4'h0, 0, 0, 0, 0, 0, 4).e);

    for (int i = 0; i < 300; i++)
      cyc("sat_run", 32'hFFFFFFFF, 1, 0, 0, 1);
    chk("sat_255", mk(0, 0, 4'h0, 0, 31, 0, 1, 1, 255).e);

    cyc("pre_rst", 32'h40335293, 1, 0, 0, 1);
    cyc("mid_rst", 32'h002081B3, 1, 1, 0, 0);
    chk("mid_rst_zero", obs_t'(0));
    cyc("resume", 32'h002081B3, 1, 0, 0, 1);
    chk("resume_add", mk(0, 0, 4'h0, 0, 3, 1, 0, 1, 0).e);

    for (int i = 0; i < 2000; i++) begin
      cyc("rand", rnd_instr(), 1'($urandom_range(0, 7) != 0),
          1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 9) == 0),
          1'($urandom_range(0, 63) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
